// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port main memory between the I-cache and
// D-cache controllers. Each granted request is run as a block transfer of
// WORDS_PER_BLOCK words, each word occupying MEM_LAT cycles on the memory.
//
// Request handshake (both sides): the requester raises req with a stable
// address (and d_we on the D-side) and keeps req high until it sees its
// done pulse. It must drop req in the done cycle; a req still high in the
// following IDLE cycle is taken as a new request. Read words are presented
// on rdata for exactly one cycle, qualified by the side's rvalid. Writeback
// words are taken from d_wdata, selected by word_idx, in the cycle that
// commits the word.
module mem_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int MEM_LAT         = 4,
  localparam int OFF_W          = $clog2(WORDS_PER_BLOCK)
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              i_rvalid,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [OFF_W-1:0]  word_idx,
  output logic              i_done,
  output logic              d_done,
  output logic              grant_d,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int LAT_W  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int BASE_W = ADDR_W - OFF_W - 2;
  localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(MEM_LAT - 1);
  localparam logic [OFF_W-1:0] IDX_MAX = OFF_W'(WORDS_PER_BLOCK - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [BASE_W-1:0] base;
  logic              we_l;
  logic              grant_r;
  logic              last_d;    // last owner: 0 = I, 1 = D
  logic [OFF_W-1:0]  idx_r;
  logic [LAT_W-1:0]  lat_cnt;

  logic take;      // a grant is issued on this edge
  logic take_d;    // the grant goes to the D-side
  logic word_end;  // final latency cycle of the current word
  logic in_access;
  logic rd_word;

  // The block offset and byte offset of the request addresses are replaced
  // by word_idx and 2'b00, so those input bits are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[OFF_W+1:0], d_addr[OFF_W+1:0]};

  assign word_end  = (lat_cnt == LAT_MAX);
  assign in_access = (state == ACCESS);

  // State register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and grant decision; a tie goes to the side that did not own
  // the memory last, and D wins the first tie after reset.
  always_comb begin
    state_nx = state;
    take     = 1'b0;
    take_d   = 1'b0;
    case (state)
      IDLE: begin
        if (i_req || d_req) begin
          take     = 1'b1;
          take_d   = d_req && (!i_req || !last_d);
          state_nx = ACCESS;
        end
      end
      ACCESS: begin
        if (word_end && (idx_r == IDX_MAX)) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Transfer context: latched at grant, then word/latency counters advance.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      base    <= '0;
      we_l    <= 1'b0;
      grant_r <= 1'b0;
      last_d  <= 1'b0;
      idx_r   <= '0;
      lat_cnt <= '0;
    end else if (take) begin
      base    <= take_d ? d_addr[ADDR_W-1:OFF_W+2] : i_addr[ADDR_W-1:OFF_W+2];
      we_l    <= take_d & d_we;
      grant_r <= take_d;
      last_d  <= take_d;
      idx_r   <= '0;
      lat_cnt <= '0;
    end else if (in_access) begin
      if (word_end) begin
        lat_cnt <= '0;
        if (idx_r != IDX_MAX) idx_r <= idx_r + OFF_W'(1);
      end else begin
        lat_cnt <= lat_cnt + LAT_W'(1);
      end
    end
  end

  // Output decode from the registered state only; reset forces all low.
  assign rd_word   = in_access && word_end && !we_l;
  assign i_rvalid  = rd_word && !grant_r;
  assign d_rvalid  = rd_word &&  grant_r;
  assign rdata     = rd_word ? mem_rdata : '0;
  assign i_done    = (state == DONE) && !grant_r;
  assign d_done    = (state == DONE) &&  grant_r;
  assign busy      = (state != IDLE);
  assign mem_en    = in_access;
  assign mem_we    = in_access && we_l;
  assign mem_addr  = {base, idx_r, 2'b00};
  assign mem_wdata = mem_we ? d_wdata : '0;
  assign word_idx  = idx_r;
  assign grant_d   = grant_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a default-sized instance against a small
// word-addressed memory model, plus a MEM_LAT=1 / 2-word instance.
module tb_mem_arbiter;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- default instance ----------------
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_rvalid, d_rvalid, i_done, d_done, grant_d, busy;
  logic        mem_en, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  word_idx;

  mem_arbiter u_dut (
    .clk(clk), .rst_b(rst_b),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .i_rvalid(i_rvalid), .d_rvalid(d_rvalid), .rdata(rdata),
    .word_idx(word_idx), .i_done(i_done), .d_done(d_done),
    .grant_d(grant_d), .busy(busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Writeback source: word n of the dirty block is 0xA0 + n.
  assign d_wdata = 32'hA0 + {30'd0, word_idx};

  // Memory model: unwritten words read back their own byte address
  // plus 0x1000_0000; written words read back what was stored.
  bit [31:0] store [0:1023];
  bit        wflag [0:1023];

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      store[mem_addr[11:2]] <= mem_wdata;
      wflag[mem_addr[11:2]] <= 1'b1;
    end
  end

  assign mem_rdata = wflag[mem_addr[11:2]] ? store[mem_addr[11:2]]
                                           : 32'h1000_0000 + mem_addr;

  // ---------------- small instance: MEM_LAT=1, 2 words ----------------
  logic        s_i_req, s_d_req, s_d_we;
  logic [31:0] s_i_addr, s_d_addr, s_d_wdata;
  logic        s_i_rvalid, s_d_rvalid, s_i_done, s_d_done, s_grant_d, s_busy;
  logic        s_mem_en, s_mem_we;
  logic [31:0] s_rdata, s_mem_addr, s_mem_wdata, s_mem_rdata;
  logic [0:0]  s_word_idx;

  mem_arbiter #(.WORDS_PER_BLOCK(2), .MEM_LAT(1)) u_small (
    .clk(clk), .rst_b(rst_b),
    .i_req(s_i_req), .i_addr(s_i_addr),
    .d_req(s_d_req), .d_we(s_d_we), .d_addr(s_d_addr), .d_wdata(s_d_wdata),
    .i_rvalid(s_i_rvalid), .d_rvalid(s_d_rvalid), .rdata(s_rdata),
    .word_idx(s_word_idx), .i_done(s_i_done), .d_done(s_d_done),
    .grant_d(s_grant_d), .busy(s_busy),
    .mem_en(s_mem_en), .mem_we(s_mem_we), .mem_addr(s_mem_addr),
    .mem_wdata(s_mem_wdata), .mem_rdata(s_mem_rdata)
  );

  assign s_mem_rdata = 32'h1000_0000 + s_mem_addr;

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check_vec(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One complete transfer on the default instance. Read words are
  // expected to be exp_base + n*exp_step. Done must show up 16 edges after
  // the granting edge (the 17th edge counting the granting edge itself).
  task automatic xfer(input bit side_d, input bit we, input logic [31:0] addr,
                      input logic [31:0] exp_base, input logic [31:0] exp_step,
                      input string tag);
    int g, lat, nrv, nwe, stray;
    bit got_done;
    logic [31:0] exp_w;
    logic [31:0] nrv_v;
    g = -1; lat = -1; nrv = 0; nwe = 0; stray = 0; got_done = 1'b0;
    exp_q.delete();
    if (!we) for (int w = 0; w < 4; w++) exp_q.push_back(exp_base + exp_step * w);
    @(negedge clk);
    check_vec({tag, "_idle_before"}, {31'd0, busy}, 32'd0);
    if (side_d) begin d_addr = addr; d_we = we; d_req = 1'b1; end
    else        begin i_addr = addr; i_req = 1'b1; end
    for (int k = 0; k < 40 && !got_done; k++) begin
      @(negedge clk);
      if (g < 0 && busy) begin
        g = k;
        check_vec({tag, "_grant_d"}, {31'd0, grant_d}, {31'd0, side_d});
      end
      if (mem_we) nwe++;
      if (side_d ? (i_rvalid || i_done) : (d_rvalid || d_done)) stray++;
      if (side_d ? d_rvalid : i_rvalid) begin
        exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        nrv_v = nrv;
        check_vec({tag, "_rdata"}, rdata, exp_w);
        check_vec({tag, "_word_idx"}, {30'd0, word_idx}, nrv_v);
        check_vec({tag, "_mem_addr"}, mem_addr, {addr[31:4], nrv_v[1:0], 2'b00});
        nrv++;
      end
      if (side_d ? d_done : i_done) begin
        got_done = 1'b1;
        lat = k - g;
        if (side_d) d_req = 1'b0; else i_req = 1'b0;
      end
    end
    if (!got_done) begin d_req = 1'b0; i_req = 1'b0; end
    check_vec({tag, "_grant_edge"}, g, 0);
    check_vec({tag, "_done_latency"}, lat, 16);
    check_vec({tag, "_rvalid_count"}, nrv, we ? 0 : 4);
    check_vec({tag, "_we_cycles"}, nwe, we ? 16 : 0);
    check_vec({tag, "_stray_other_side"}, stray, 0);
  endtask

  // Waits (bounded) for a side's done pulse and drops its req there.
  task automatic wait_done(input bit side_d, input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (side_d ? d_done : i_done) begin
        seen = 1'b1;
        if (side_d) d_req = 1'b0; else i_req = 1'b0;
      end
    end
    if (!seen) begin d_req = 1'b0; i_req = 1'b0; end
    check_vec({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit found;
    int n_done;
    int s_g, s_lat, s_nrv;
    bit s_got;
    logic [31:0] s_nrv_v;

    rst_b = 1'b0;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0;
    s_i_req = 1'b0; s_d_req = 1'b0; s_d_we = 1'b0;
    s_i_addr = '0; s_d_addr = '0; s_d_wdata = '0;

    // Reset state: every output low.
    #1;
    check_vec("rst_busy",      {31'd0, busy},     32'd0);
    check_vec("rst_mem_en",    {31'd0, mem_en},   32'd0);
    check_vec("rst_mem_we",    {31'd0, mem_we},   32'd0);
    check_vec("rst_grant_d",   {31'd0, grant_d},  32'd0);
    check_vec("rst_rvalid",    {30'd0, i_rvalid, d_rvalid}, 32'd0);
    check_vec("rst_done",      {30'd0, i_done, d_done},     32'd0);
    check_vec("rst_rdata",     rdata,             32'd0);
    check_vec("rst_mem_addr",  mem_addr,          32'd0);
    check_vec("rst_mem_wdata", mem_wdata,         32'd0);
    check_vec("rst_word_idx",  {30'd0, word_idx}, 32'd0);
    repeat (2) @(negedge clk);
    rst_b = 1'b1;

    // I-only refill of the block holding 0x1234.
    xfer(1'b0, 1'b0, 32'h0000_1234, 32'h1000_1230, 32'd4, "i_refill");

    // D writeback of block 0x40, then an immediate D refill of it.
    xfer(1'b1, 1'b1, 32'h0000_0040, 32'd0, 32'd0, "d_wb");
    for (int i = 0; i < 4; i++)
      check_vec("wb_mem_word", store[16 + i], 32'hA0 + i);
    xfer(1'b1, 1'b0, 32'h0000_0040, 32'h0000_00A0, 32'd1, "d_refill");

    // Reset in the middle of word 2 of an I refill.
    @(negedge clk);
    i_addr = 32'h0000_2000;
    i_req  = 1'b1;
    found  = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (busy && word_idx == 2'd2) found = 1'b1;
    end
    check_vec("midrst_reached_word2", {31'd0, found}, 32'd1);
    rst_b = 1'b0;
    #1;
    check_vec("midrst_mem_en",   {31'd0, mem_en},   32'd0);
    check_vec("midrst_mem_we",   {31'd0, mem_we},   32'd0);
    check_vec("midrst_busy",     {31'd0, busy},     32'd0);
    check_vec("midrst_word_idx", {30'd0, word_idx}, 32'd0);
    check_vec("midrst_rdata",    rdata,             32'd0);
    check_vec("midrst_mem_addr", mem_addr,          32'd0);
    i_req  = 1'b0;
    n_done = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (i_done || d_done) n_done++;
    end
    rst_b = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (i_done || d_done) n_done++;
    end
    check_vec("midrst_no_done", n_done, 0);
    xfer(1'b0, 1'b0, 32'h0000_2000, 32'h1000_2000, 32'd4, "restart");

    // Round-robin ties from a fresh reset.
    pulse_reset();
    @(negedge clk);
    i_addr = 32'h0000_0300; d_addr = 32'h0000_0400; d_we = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    @(negedge clk);
    check_vec("tie1_busy",    {31'd0, busy},    32'd1);
    check_vec("tie1_grant_d", {31'd0, grant_d}, 32'd1);
    wait_done(1'b1, "tie1");
    @(negedge clk);
    check_vec("tie1_gap_idle", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check_vec("tie2_busy",    {31'd0, busy},    32'd1);
    check_vec("tie2_grant_i", {31'd0, grant_d}, 32'd0);
    wait_done(1'b0, "tie2");
    @(negedge clk);
    check_vec("tie3_idle", {31'd0, busy}, 32'd0);
    i_req = 1'b1; d_req = 1'b1;
    @(negedge clk);
    check_vec("tie3_grant_d", {31'd0, grant_d}, 32'd1);
    wait_done(1'b1, "tie3");
    wait_done(1'b0, "tie3_i");

    // Small instance: one word per cycle, 2-word block.
    @(negedge clk);
    s_i_addr = 32'h0000_0100;
    s_i_req  = 1'b1;
    s_g = -1; s_lat = -1; s_nrv = 0; s_got = 1'b0;
    for (int k = 0; k < 20 && !s_got; k++) begin
      @(negedge clk);
      if (s_g < 0 && s_busy) s_g = k;
      if (s_i_rvalid) begin
        s_nrv_v = s_nrv;
        check_vec("small_word_idx", {31'd0, s_word_idx}, s_nrv_v);
        check_vec("small_rdata", s_rdata, 32'h1000_0100 + 4 * s_nrv_v);
        check_vec("small_rvalid_cycle", k - s_g, s_nrv);
        s_nrv++;
      end
      if (s_i_done) begin
        s_got = 1'b1;
        s_lat = k - s_g;
        s_i_req = 1'b0;
      end
    end
    s_i_req = 1'b0;
    check_vec("small_grant_edge", s_g, 0);
    check_vec("small_done_latency", s_lat, 2);
    check_vec("small_rvalid_count", s_nrv, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
